// File: rtl/md5_pad_ctrl_if.sv
// ============================================================================
//  md5_pad_ctrl_if : message stream, md5sum core and digest signals of the
//  MD5 padding front-end.   Rev 1.0
// ============================================================================
`default_nettype none

interface md5_pad_ctrl_if;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_last;
    logic [2:0]  s_bytes;
    logic        s_ready;
    logic        core_rst_n;
    logic        core_rdy;
    logic [31:0] core_msg;
    logic        core_write_en;
    logic        core_done;
    logic [31:0] core_a, core_b, core_c, core_d;
    logic [31:0] digest_a, digest_b, digest_c, digest_d;
    logic        digest_valid;
    logic        busy;
    logic        len_err;

    modport slave (
        input  s_data, s_valid, s_last, s_bytes, core_rdy, core_done,
               core_a, core_b, core_c, core_d,
        output s_ready, core_rst_n, core_msg, core_write_en,
               digest_a, digest_b, digest_c, digest_d, digest_valid, busy, len_err
    );

    modport master (
        output s_data, s_valid, s_last, s_bytes, core_rdy, core_done,
               core_a, core_b, core_c, core_d,
        input  s_ready, core_rst_n, core_msg, core_write_en,
               digest_a, digest_b, digest_c, digest_d, digest_valid, busy, len_err
    );
endinterface

`default_nettype wire

// File: rtl/md5_pad_ctrl.sv
// ============================================================================
//  md5_pad_ctrl : pads a 32-bit little-endian word stream for MD5, feeds the
//  md5sum core block by block and presents the final digest.   Rev 1.0
// ============================================================================
`default_nettype none

module md5_pad_ctrl #(
    parameter int LEN_W      = 32,
    parameter int RST_CYCLES = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    md5_pad_ctrl_if.slave bus
);

    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_CORE_RST  = 2'd0,
        ST_WAIT_RDY  = 2'd1,
        ST_FEED      = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        PH_DATA = 2'd0,
        PH_PAD  = 2'd1,
        PH_FILL = 2'd2
    } phase_t;

    state_t            state_q, state_d;
    phase_t            phase_q, phase_d;
    logic [4:0]        wc_q, wc_d;
    logic [RC_W-1:0]   rcnt_q, rcnt_d;
    logic [LEN_W-1:0]  bytecnt_q, bytecnt_d;
    logic              defer_q, defer_d;
    logic              last_q, last_d;
    logic              we_q, we_d;
    logic [31:0]       msg_q, msg_d;
    logic [127:0]      dig_q, dig_d;
    logic              dv_q, dv_d;
    logic              busy_q, busy_d;
    logic              lerr_q, lerr_d;

    logic              ready;
    logic              emit;
    logic              pad_here;
    logic [2:0]        add;
    logic [31:0]       word;
    logic [4:0]        bsh;
    logic [LEN_W:0]    sum;
    logic [63:0]       len64;

    assign bsh   = {bus.s_bytes[1:0], 3'b000};
    assign len64 = {{(61-LEN_W){1'b0}}, bytecnt_q, 3'b000};
    assign sum   = {1'b0, bytecnt_q} + {{(LEN_W-2){1'b0}}, add};

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        wc_d      = wc_q;
        rcnt_d    = rcnt_q;
        bytecnt_d = bytecnt_q;
        defer_d   = defer_q;
        last_d    = last_q;
        msg_d     = msg_q;
        dig_d     = dig_q;
        busy_d    = busy_q;
        lerr_d    = lerr_q;
        we_d      = 1'b0;
        dv_d      = 1'b0;
        ready     = 1'b0;
        emit      = 1'b0;
        pad_here  = 1'b0;
        add       = 3'd0;
        word      = 32'h0;

        unique case (state_q)
            ST_CORE_RST: begin
                if (rcnt_q == RC_W'(RST_CYCLES - 1)) begin
                    state_d   = ST_WAIT_RDY;
                    rcnt_d    = '0;
                    wc_d      = 5'd0;
                    phase_d   = PH_DATA;
                    bytecnt_d = '0;
                    defer_d   = 1'b0;
                    last_d    = 1'b0;
                    lerr_d    = 1'b0;
                end else begin
                    rcnt_d = rcnt_q + RC_W'(1);
                end
            end
            ST_WAIT_RDY: begin
                if (bus.core_rdy) state_d = ST_FEED;
            end
            ST_FEED: begin
                unique case (phase_q)
                    PH_DATA: begin
                        ready = 1'b1;
                        if (bus.s_valid) begin
                            emit   = 1'b1;
                            busy_d = 1'b1;
                            if (!bus.s_last) begin
                                word = bus.s_data;
                                add  = 3'd4;
                            end else if (bus.s_bytes[2]) begin
                                word    = bus.s_data;
                                add     = 3'd4;
                                phase_d = PH_PAD;
                            end else begin
                                // keep the valid low bytes, 0x80 marker right above them
                                word     = (bus.s_data & ((32'h1 << bsh) - 32'h1)) | (32'h80 << bsh);
                                add      = bus.s_bytes;
                                phase_d  = PH_FILL;
                                pad_here = 1'b1;
                            end
                        end
                    end
                    PH_PAD: begin
                        emit     = 1'b1;
                        word     = 32'h80;
                        phase_d  = PH_FILL;
                        pad_here = 1'b1;
                    end
                    default: begin
                        emit = 1'b1;
                        if (!defer_q && wc_q == 5'd14) begin
                            word = len64[31:0];
                        end else if (!defer_q && wc_q == 5'd15) begin
                            word   = len64[63:32];
                            last_d = 1'b1;
                        end
                    end
                endcase
                // marker too late for the length words: this block closes with zeros
                if (pad_here && wc_q >= 5'd14) defer_d = 1'b1;
                if (emit) begin
                    we_d  = 1'b1;
                    msg_d = word;
                    wc_d  = wc_q + 5'd1;
                    if (wc_q == 5'd15) state_d = ST_WAIT_DONE;
                end
            end
            default: begin
                if (bus.core_done) begin
                    if (last_q) begin
                        dig_d   = {bus.core_a, bus.core_b, bus.core_c, bus.core_d};
                        dv_d    = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_CORE_RST;
                    end else begin
                        wc_d    = 5'd0;
                        defer_d = 1'b0;
                        state_d = ST_WAIT_RDY;
                    end
                end
            end
        endcase

        if (add != 3'd0) begin
            if (sum[LEN_W]) begin
                bytecnt_d = '1;
                lerr_d    = 1'b1;
            end else begin
                bytecnt_d = sum[LEN_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_CORE_RST;
            phase_q   <= PH_DATA;
            wc_q      <= 5'd0;
            rcnt_q    <= '0;
            bytecnt_q <= '0;
            defer_q   <= 1'b0;
            last_q    <= 1'b0;
            we_q      <= 1'b0;
            msg_q     <= 32'h0;
            dig_q     <= 128'h0;
            dv_q      <= 1'b0;
            busy_q    <= 1'b0;
            lerr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            wc_q      <= wc_d;
            rcnt_q    <= rcnt_d;
            bytecnt_q <= bytecnt_d;
            defer_q   <= defer_d;
            last_q    <= last_d;
            we_q      <= we_d;
            msg_q     <= msg_d;
            dig_q     <= dig_d;
            dv_q      <= dv_d;
            busy_q    <= busy_d;
            lerr_q    <= lerr_d;
        end
    end

    assign bus.s_ready       = ready;
    assign bus.core_rst_n    = (state_q != ST_CORE_RST);
    assign bus.core_write_en = we_q;
    assign bus.core_msg      = msg_q;
    assign bus.digest_a      = dig_q[127:96];
    assign bus.digest_b      = dig_q[95:64];
    assign bus.digest_c      = dig_q[63:32];
    assign bus.digest_d      = dig_q[31:0];
    assign bus.digest_valid  = dv_q;
    assign bus.busy          = busy_q;
    assign bus.len_err       = lerr_q;

endmodule

`default_nettype wire

// File: tb/tb_md5_pad_ctrl.sv
// ============================================================================
//  tb_md5_pad_ctrl : scoreboard bench with a behavioural md5sum core model.
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_md5_pad_ctrl;
    localparam int RST_CYCLES = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    md5_pad_ctrl_if bus();

    md5_pad_ctrl #(.LEN_W(32), .RST_CYCLES(RST_CYCLES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed { logic known; logic [127:0] d; } dig_t;

    int          checks   = 0;
    int          failures = 0;
    int          word_idx = 0;
    logic [31:0] exp_w[$];
    dig_t        exp_d[$];
    logic [31:0] e_w;
    dig_t        e_d;
    logic [127:0] e_dig;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural md5sum core ----------------
    logic [31:0] kt[64];
    int unsigned sh[64];
    logic [31:0] ch[4];
    logic [31:0] m[16];
    int          n_w = 0, dly = 0, rst_run = 0;

    initial begin
        int unsigned s4[4][4];
        real r;
        s4 = '{'{7,12,17,22}, '{5,9,14,20}, '{4,11,16,23}, '{6,10,15,21}};
        for (int i = 0; i < 64; i++) begin
            r = $sin(real'(i + 1));
            if (r < 0.0) r = -r;
            kt[i] = 32'(longint'($floor(r * 4294967296.0)));
            sh[i] = s4[i/16][i%4];
        end
    end

    task automatic md5_blk();
        logic [31:0] a, b, c, d, f, t;
        int g;
        a = ch[0]; b = ch[1]; c = ch[2]; d = ch[3];
        for (int i = 0; i < 64; i++) begin
            case (i / 16)
                0:       begin f = (b & c) | (~b & d); g = i;              end
                1:       begin f = (d & b) | (~d & c); g = (5*i + 1) % 16; end
                2:       begin f = b ^ c ^ d;          g = (3*i + 5) % 16; end
                default: begin f = c ^ (b | ~d);       g = (7*i) % 16;     end
            endcase
            t = f + a + kt[i] + m[g];
            a = d; d = c; c = b;
            b = b + ((t << sh[i]) | (t >> (32 - sh[i])));
        end
        ch[0] = ch[0] + a; ch[1] = ch[1] + b; ch[2] = ch[2] + c; ch[3] = ch[3] + d;
    endtask

    always @(negedge clk) begin
        if (bus.core_rst_n !== 1'b1) begin
            rst_run++;
            ch = '{32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476};
            n_w = 0; dly = 0;
            bus.core_rdy  = 1'b1;
            bus.core_done = 1'b0;
        end else begin
            if (rst_run > 0) begin
                check("core_rst_len", 128'(rst_run >= RST_CYCLES), 128'd1);
                rst_run = 0;
            end
            bus.core_done = 1'b0;
            if (bus.core_write_en === 1'b1) begin
                m[n_w] = bus.core_msg;
                n_w++;
                if (n_w == 16) begin
                    bus.core_rdy = 1'b0; dly = 3; n_w = 0;
                end
            end else if (dly > 0) begin
                dly--;
                if (dly == 0) begin
                    md5_blk();
                    bus.core_done = 1'b1;
                    bus.core_rdy  = 1'b1;
                end
            end
        end
        bus.core_a = ch[0]; bus.core_b = ch[1]; bus.core_c = ch[2]; bus.core_d = ch[3];
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.core_write_en === 1'b1) begin
                if (exp_w.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL word_unexpected: got %h expected none", bus.core_msg);
                end else begin
                    e_w = exp_w.pop_front();
                    check($sformatf("word%0d", word_idx), 128'(bus.core_msg), 128'(e_w));
                end
                word_idx++;
            end
            if (bus.digest_valid === 1'b1) begin
                if (exp_d.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL digest_unexpected: got %h expected none", bus.digest_a);
                end else begin
                    e_d   = exp_d.pop_front();
                    e_dig = e_d.known ? e_d.d : {bus.core_a, bus.core_b, bus.core_c, bus.core_d};
                    check("digest", {bus.digest_a, bus.digest_b, bus.digest_c, bus.digest_d}, e_dig);
                    check("len_err", 128'(bus.len_err), 128'd0);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_padded(input logic [7:0] msg[$]);
        logic [7:0]  p[$];
        logic [63:0] bl;
        p  = msg;
        bl = 64'(msg.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 0; i < 8; i++) p.push_back(bl[8*i +: 8]);
        for (int i = 0; i < p.size(); i += 4) exp_w.push_back({p[i+3], p[i+2], p[i+1], p[i]});
    endtask

    // entered and left at a negedge; stops early after max_words handshakes
    task automatic send_msg(input logic [7:0] msg[$], input bit gaps, input int max_words);
        int L, nw, t;
        logic [31:0] d;
        L  = msg.size();
        nw = (L == 0) ? 1 : (L + 3) / 4;
        for (int w = 0; w < nw && w < max_words; w++) begin
            if (gaps) begin
                bus.s_valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            d = 32'hA5A5A5A5;
            for (int b = 0; b < 4; b++) if (4*w + b < L) d[8*b +: 8] = msg[4*w + b];
            bus.s_data  = d;
            bus.s_valid = 1'b1;
            bus.s_last  = (w == nw - 1);
            bus.s_bytes = (w == nw - 1) ? 3'(L - 4*w) : 3'd4;
            t = 0;
            while (bus.s_ready !== 1'b1 && t < 500) begin
                @(negedge clk);
                t++;
            end
            if (t >= 500) begin
                checks++; failures++;
                $display("FAIL s_ready_timeout: got 0 expected 1 (word %0d)", w);
                bus.s_valid = 1'b0;
                return;
            end
            @(posedge clk);
            @(negedge clk);
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic wait_digest(input string name);
        int t = 0;
        while (exp_d.size() != 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check({name, "_done"}, 128'(exp_d.size()), 128'd0);
        check({name, "_words_left"}, 128'(exp_w.size()), 128'd0);
        check({name, "_busy"}, 128'(bus.busy), 128'd0);
        exp_d.delete();
        exp_w.delete();
        word_idx = 0;
    endtask

    logic [7:0] hello[$];
    logic [7:0] msg[$];

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.s_valid = 1'b0; bus.s_data = 32'h0; bus.s_last = 1'b0; bus.s_bytes = 3'd0;
        hello = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F};
        repeat (3) @(negedge clk);
        check("rst_s_ready",    128'(bus.s_ready), 128'd0);
        check("rst_core_rst_n", 128'(bus.core_rst_n), 128'd0);
        check("rst_write_en",   128'(bus.core_write_en), 128'd0);
        check("rst_core_msg",   128'(bus.core_msg), 128'd0);
        check("rst_digest", {bus.digest_a, bus.digest_b, bus.digest_c, bus.digest_d}, 128'd0);
        check("rst_flags", 128'({bus.digest_valid, bus.busy, bus.len_err}), 128'd0);
        rst_n = 1'b1;

        // T1 "hello"
        exp_w.push_back(32'h6C6C6568);
        exp_w.push_back(32'h0000806F);
        repeat (12) exp_w.push_back(32'h0);
        exp_w.push_back(32'h00000028);
        exp_w.push_back(32'h0);
        exp_d.push_back({1'b1, 128'h2a40415d_762a4bbc_919d71b9_92c51710});
        send_msg(hello, 1'b0, 1000);
        wait_digest("t1");

        // T2 119 bytes: 2 blocks, partial last word
        msg = hello;
        repeat (109) msg.push_back(8'h20);
        msg.push_back(8'h77); msg.push_back(8'h6F); msg.push_back(8'h72);
        msg.push_back(8'h6C); msg.push_back(8'h64);
        push_padded(msg);
        exp_d.push_back({1'b1, 128'h3e9bf178_d8e32df5_c353bf0d_d2e0876c});
        send_msg(msg, 1'b0, 1000);
        wait_digest("t2");

        // T3 empty message
        exp_w.push_back(32'h00000080);
        repeat (15) exp_w.push_back(32'h0);
        exp_d.push_back({1'b1, 128'hd98c1dd4_04b2008f_980980e9_7e42f8ec});
        msg.delete();
        send_msg(msg, 1'b0, 1000);
        wait_digest("t3");

        // T4 56 bytes: marker at word 14 forces an extra block
        msg.delete();
        for (int i = 0; i < 56; i++) msg.push_back(8'(i * 7 + 3));
        repeat (14) exp_w.push_back(32'h0);
        exp_w.delete();
        for (int i = 0; i < 14; i++) exp_w.push_back({msg[4*i+3], msg[4*i+2], msg[4*i+1], msg[4*i]});
        exp_w.push_back(32'h00000080);
        exp_w.push_back(32'h0);
        repeat (14) exp_w.push_back(32'h0);
        exp_w.push_back(32'h000001C0);
        exp_w.push_back(32'h0);
        exp_d.push_back({1'b0, 128'h0});
        send_msg(msg, 1'b0, 1000);
        wait_digest("t4");

        // T5 64 bytes, contiguous then gapped
        msg.delete();
        for (int i = 0; i < 64; i++) msg.push_back(8'(i * 13 + 1));
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 16; i++) exp_w.push_back({msg[4*i+3], msg[4*i+2], msg[4*i+1], msg[4*i]});
            exp_w.push_back(32'h00000080);
            repeat (13) exp_w.push_back(32'h0);
            exp_w.push_back(32'h00000200);
            exp_w.push_back(32'h0);
            exp_d.push_back({1'b0, 128'h0});
            send_msg(msg, pass[0], 1000);
            wait_digest(pass == 0 ? "t5" : "t5_gap");
        end

        // T6 reset during first block of the T2 message
        msg = hello;
        repeat (109) msg.push_back(8'h20);
        msg.push_back(8'h77); msg.push_back(8'h6F); msg.push_back(8'h72);
        msg.push_back(8'h6C); msg.push_back(8'h64);
        push_padded(msg);
        send_msg(msg, 1'b0, 8);
        repeat (3) @(negedge clk);
        check("t6_busy_mid", 128'(bus.busy), 128'd1);
        check("t6_words_sent", 128'(word_idx), 128'd8);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        exp_w.delete();
        word_idx = 0;
        check("t6_rst_core_rst_n", 128'(bus.core_rst_n), 128'd0);
        check("t6_rst_busy", 128'(bus.busy), 128'd0);
        check("t6_rst_digest", {bus.digest_a, bus.digest_b, bus.digest_c, bus.digest_d}, 128'd0);
        rst_n = 1'b1;
        exp_w.push_back(32'h6C6C6568);
        exp_w.push_back(32'h0000806F);
        repeat (12) exp_w.push_back(32'h0);
        exp_w.push_back(32'h00000028);
        exp_w.push_back(32'h0);
        exp_d.push_back({1'b1, 128'h2a40415d_762a4bbc_919d71b9_92c51710});
        send_msg(hello, 1'b0, 1000);
        wait_digest("t6_t1");

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire
